// File: rtl/cook_timer.sv
// Cook-time countdown and magnetron duty gating, downstream of the microwave control FSM.
// Counts whole seconds from a loaded duration and reports expiry back to the FSM.
module cook_timer #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enDuration,
    input  logic [15:0] inDuration,
    input  logic        enHeatingLevel,
    input  logic [1:0]  inHeatLevel,
    input  logic        enOut,
    input  logic        enEnd,
    input  logic        enReset,
    output logic        doneCount,
    output logic [15:0] timeLeft,
    output logic        magnetronOn,
    output logic        lampOn,
    output logic        doneLed,
    output logic        secTick
);

    localparam int PRE_W = $clog2(TICKS_PER_SEC);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

    logic [15:0]      count_q, count_d;
    logic [1:0]       level_q, level_d;
    logic             armed_q, armed_d;
    logic             done_q, done_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       phase_q, phase_d;
    logic             mag_q, mag_d;
    logic             lamp_q, lamp_d;
    logic             led_q, led_d;
    logic             tick_q, tick_d;

    logic running;
    logic hold_ok;

    assign running = enOut & armed_q & ~done_q;
    // Loads are accepted only while not actively cooking, so a held enDuration cannot restart a run.
    assign hold_ok = ~enOut | ~armed_q;

    always_comb begin
        count_d = count_q;
        level_d = level_q;
        armed_d = armed_q;
        done_d  = done_q;
        pre_d   = pre_q;
        phase_d = phase_q;
        mag_d   = running & (phase_q <= level_q);
        lamp_d  = running;
        led_d   = enEnd;
        tick_d  = 1'b0;

        if (enReset) begin
            count_d = '0;
            level_d = '0;
            armed_d = 1'b0;
            done_d  = 1'b0;
            pre_d   = '0;
            phase_d = '0;
        end else begin
            if (enHeatingLevel & hold_ok) begin
                level_d = inHeatLevel;
            end
            if (enDuration & hold_ok) begin
                count_d = inDuration;
                armed_d = 1'b1;
                done_d  = 1'b0;
                pre_d   = '0;
                phase_d = '0;
            end else if (running) begin
                // A zero duration expires immediately instead of wrapping below zero.
                if (count_q == 16'd0) begin
                    done_d = 1'b1;
                end else if (pre_q == PRE_LAST) begin
                    pre_d   = '0;
                    count_d = count_q - 16'd1;
                    phase_d = phase_q + 2'd1;
                    tick_d  = 1'b1;
                    if (count_q == 16'd1) begin
                        done_d = 1'b1;
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            level_q <= '0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
            pre_q   <= '0;
            phase_q <= '0;
            mag_q   <= 1'b0;
            lamp_q  <= 1'b0;
            led_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            level_q <= level_d;
            armed_q <= armed_d;
            done_q  <= done_d;
            pre_q   <= pre_d;
            phase_q <= phase_d;
            mag_q   <= mag_d;
            lamp_q  <= lamp_d;
            led_q   <= led_d;
            tick_q  <= tick_d;
        end
    end

    assign doneCount   = done_q;
    assign timeLeft    = count_q;
    assign magnetronOn = mag_q;
    assign lampOn      = lamp_q;
    assign doneLed     = led_q;
    assign secTick     = tick_q;

endmodule

// File: tb/tb_cook_timer.sv
// Bench for cook_timer: directed scenarios plus random traffic, checked against a
// reference model that tracks elapsed running cycles rather than a prescaler.
module tb_cook_timer;

    localparam int TPS = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        enDuration;
    logic [15:0] inDuration;
    logic        enHeatingLevel;
    logic [1:0]  inHeatLevel;
    logic        enOut;
    logic        enEnd;
    logic        enReset;
    logic        doneCount;
    logic [15:0] timeLeft;
    logic        magnetronOn;
    logic        lampOn;
    logic        doneLed;
    logic        secTick;

    cook_timer #(.TICKS_PER_SEC(TPS)) dut (
        .clock(clock), .reset(reset),
        .enDuration(enDuration), .inDuration(inDuration),
        .enHeatingLevel(enHeatingLevel), .inHeatLevel(inHeatLevel),
        .enOut(enOut), .enEnd(enEnd), .enReset(enReset),
        .doneCount(doneCount), .timeLeft(timeLeft), .magnetronOn(magnetronOn),
        .lampOn(lampOn), .doneLed(doneLed), .secTick(secTick)
    );

    always #5 clock = ~clock;

    // Reference model: loaded duration and running cycles spent since the load.
    int   m_dur;
    int   m_run;
    bit   m_armed;
    bit   m_done;
    int   m_level;
    bit   e_mag, e_lamp, e_led, e_tick;
    int   n_checks;
    int   n_fail;
    int   highs;

    function automatic int m_left();
        return m_dur - m_run / TPS;
    endfunction

    task automatic model_clear();
        m_dur = 0; m_run = 0; m_armed = 0; m_done = 0; m_level = 0;
        e_mag = 0; e_lamp = 0; e_led = 0; e_tick = 0;
    endtask

    task automatic model_edge();
        bit run;
        bit ok;
        int ph;
        run    = enOut && m_armed && !m_done;
        ok     = !enOut || !m_armed;
        ph     = (m_run / TPS) % 4;
        e_mag  = run && (ph <= m_level);
        e_lamp = run;
        e_led  = enEnd;
        e_tick = 0;
        if (enReset) begin
            m_dur = 0; m_run = 0; m_armed = 0; m_done = 0; m_level = 0;
        end else begin
            if (enHeatingLevel && ok) m_level = int'(inHeatLevel);
            if (enDuration && ok) begin
                m_dur = int'(inDuration); m_run = 0; m_armed = 1; m_done = 0;
            end else if (run) begin
                if (m_left() == 0) begin
                    m_done = 1;
                end else begin
                    m_run++;
                    if (m_run % TPS == 0) begin
                        e_tick = 1;
                        if (m_left() == 0) m_done = 1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("timeLeft", timeLeft, 16'(m_left()));
        chk("doneCount", 16'(doneCount), 16'(m_done));
        chk("magnetronOn", 16'(magnetronOn), 16'(e_mag));
        chk("lampOn", 16'(lampOn), 16'(e_lamp));
        chk("doneLed", 16'(doneLed), 16'(e_led));
        chk("secTick", 16'(secTick), 16'(e_tick));
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check_all();
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        enDuration = 0; inDuration = 0; enHeatingLevel = 0; inHeatLevel = 0;
        enOut = 0; enEnd = 0; enReset = 0;
        reset = 1'b1;
        model_clear();
        #2;
        chk("reset_timeLeft", timeLeft, 16'd0);
        chk("reset_doneCount", 16'(doneCount), 16'd0);
        chk("reset_magnetron", 16'(magnetronOn), 16'd0);
        reset = 1'b0;

        // Manual cook: keypad entry tracked, then high power run of 3 s.
        enDuration = 1; inDuration = 5;
        step(); chk("manual_load5", timeLeft, 16'd5);
        inDuration = 3;
        step(); chk("manual_load3", timeLeft, 16'd3);
        enDuration = 0; enHeatingLevel = 1; inHeatLevel = 2'b11;
        step();
        enHeatingLevel = 0; enOut = 1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 4) chk("manual_first_dec", timeLeft, 16'd2);
            if (i < 12) chk("manual_not_done", 16'(doneCount), 16'd0);
            chk("manual_mag_high", 16'(magnetronOn), 16'd1);
        end
        chk("manual_done12", 16'(doneCount), 16'd1);
        enOut = 0; enEnd = 1;
        step();
        enEnd = 0; enReset = 1;
        step();
        enReset = 0;

        // Auto mode: enDuration and enOut held together load only once.
        enDuration = 1; enOut = 1; inDuration = 10;
        for (int i = 1; i <= 41; i++) begin
            step();
            if (i == 1) chk("auto_load10", timeLeft, 16'd10);
            if (i == 5) chk("auto_dec9", timeLeft, 16'd9);
            if (i == 40) chk("auto_not_done40", 16'(doneCount), 16'd0);
        end
        chk("auto_done41", 16'(doneCount), 16'd1);
        enReset = 1;
        step();
        chk("auto_clr_done", 16'(doneCount), 16'd0);
        chk("auto_clr_time", timeLeft, 16'd0);
        enReset = 0; enDuration = 0; enOut = 0;

        // Duty patterns: low then medium over 8 seconds.
        for (int lv = 0; lv < 2; lv++) begin
            enDuration = 1; inDuration = 8; enHeatingLevel = 1; inHeatLevel = 2'(lv);
            step();
            enDuration = 0; enHeatingLevel = 0; enOut = 1;
            highs = 0;
            for (int i = 0; i < 33; i++) begin
                step();
                if (magnetronOn) highs++;
            end
            chk("duty_highs", 16'(highs), (lv == 0) ? 16'd8 : 16'd16);
            enOut = 0; enReset = 1;
            step();
            enReset = 0;
        end

        // Pause mid-prescale then resume with enDuration also high.
        enDuration = 1; inDuration = 8; enHeatingLevel = 1; inHeatLevel = 2'b11;
        step();
        enDuration = 0; enHeatingLevel = 0; enOut = 1;
        repeat (10) step();
        chk("pause_at6", timeLeft, 16'd6);
        enOut = 0;
        repeat (20) step();
        chk("pause_hold6", timeLeft, 16'd6);
        chk("pause_lamp_off", 16'(lampOn), 16'd0);
        enOut = 1; enDuration = 1; inDuration = 30;
        step();
        chk("resume_no_reload", timeLeft, 16'd6);
        step();
        chk("resume_partial_pre", timeLeft, 16'd5);
        enDuration = 0; enOut = 0; enReset = 1;
        step();
        enReset = 0;

        // Zero duration expires on the next running edge without wrapping.
        enDuration = 1; inDuration = 0;
        step();
        enDuration = 0; enOut = 1;
        step();
        chk("zero_done", 16'(doneCount), 16'd1);
        chk("zero_time", timeLeft, 16'd0);
        repeat (5) step();
        chk("zero_no_wrap", timeLeft, 16'd0);
        enOut = 0; enReset = 1; enDuration = 1; inDuration = 7;
        step();
        chk("reset_beats_load", timeLeft, 16'd0);
        enReset = 0;
        step();
        chk("load_after_reset", timeLeft, 16'd7);

        // Asynchronous reset between edges mid-count.
        enDuration = 0; enOut = 1;
        repeat (6) step();
        #3 reset = 1'b1;
        #1;
        chk("areset_time", timeLeft, 16'd0);
        chk("areset_done", 16'(doneCount), 16'd0);
        chk("areset_mag", 16'(magnetronOn), 16'd0);
        chk("areset_lamp", 16'(lampOn), 16'd0);
        model_clear();
        #1 reset = 1'b0;
        enDuration = 1; inDuration = 4;
        step();
        chk("areset_reload", timeLeft, 16'd4);
        enDuration = 0;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            enReset        = ($urandom_range(0, 99) < 2);
            enDuration     = ($urandom_range(0, 99) < 10);
            enOut          = ($urandom_range(0, 99) < 75);
            enHeatingLevel = ($urandom_range(0, 99) < 10);
            inHeatLevel    = 2'($urandom_range(0, 3));
            inDuration     = 16'($urandom_range(0, 5));
            enEnd          = 1'($urandom_range(0, 1));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cook_timer.md
# cook_timer

Countdown and power-delivery datapath directly downstream of the microwave control FSM. It consumes the FSM's `enDuration`/`inDuration`, `enHeatingLevel`/`inHeatLevel`, `enOut`, `enEnd` and `enReset` strobes. It counts the cook time down in whole seconds and gates the magnetron with a heat-level duty pattern. It returns `doneCount` to the FSM and drives remaining time to the display path.

## Interface
- `TICKS_PER_SEC`, default 50000000: clock cycles per one-second tick. Must be ≥2.
- `clock` in 1: system clock. All state changes on its rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state immediately.
- `enDuration` in 1: duration load request from the FSM.
- `inDuration` in 16: cook time in binary seconds, 0–65535.
- `enHeatingLevel` in 1: heat-level load request.
- `inHeatLevel` in 2: heat level. 11 = high, 10 = normal, 01 = medium, 00 = low.
- `enOut` in 1: run request. High means cook; low means pause or hold.
- `enEnd` in 1: FSM is in DONE.
- `enReset` in 1: synchronous clear from the FSM.
- `doneCount` out 1: level. Set when the countdown expires; held until cleared.
- `timeLeft` out 16: remaining seconds, binary.
- `magnetronOn` out 1: registered power-gate output.
- `lampOn` out 1: registered. High while running.
- `doneLed` out 1: registered copy of `enEnd`.
- `secTick` out 1: one-cycle pulse on each decrement.

## Operation
- Internal state:
  - `count[15:0]`, which is `timeLeft`.
  - `level[1:0]`.
  - `armed` flag.
  - prescaler `pre` covering 0..TICKS_PER_SEC-1.
  - duty `phase[1:0]`.
  - `doneCount` register.
- `running` = `enOut & armed & !doneCount`.
- Load rule: a load occurs on an edge where `enDuration & (!enOut | !armed)`. On a load:
  - `count <= inDuration`, `armed <= 1`, `doneCount <= 0`, `pre <= 0`, `phase <= 0`.
- Consequences of the load rule:
  - Manual entry: `enDuration` is held with `enOut` low, so `count` tracks the keypad value continuously.
  - Auto modes: `enDuration` and `enOut` are held together, so only the first cycle loads. Later cycles count down.
- Heat level: `level <= inHeatLevel` when `enHeatingLevel & (!enOut | !armed)`. It is also captured on the same edge as a duration load if both enables are high.
- Countdown while `running`:
  - `pre` increments. When it reaches `TICKS_PER_SEC-1`, it wraps to 0 and a tick occurs.
  - On a tick: `count <= count-1`, `phase <= phase+1` (wraps mod 4), `secTick` pulses.
  - If `count == 1` on the tick, `doneCount <= 1` on the same edge. `count` becomes 0.
  - If running with `count == 0` (zero duration loaded), `doneCount <= 1` on the next edge. No tick is required and there is no underflow.
- Pause: `enOut` low with `armed` set freezes `count`, `pre` and `phase`. Raising `enOut` resumes without a reload, even if `enDuration` is also high.
- Duty gating: `magnetronOn <= running & (phase <= level)`. Over a 4-second window this gives high 4/4, normal 3/4, medium 2/4, low 1/4.
- `lampOn <= running`. `doneLed <= enEnd`.
- `enReset` (synchronous) clears to zero: `count`, `armed`, `doneCount`, `pre`, `phase`, `level`.
- `doneCount` clears only on `enReset`, on a load, or on `reset`. Once set, it stops the countdown.

## Timing
- Async `reset` clears every register, so all outputs read 0 while it is asserted. That includes `timeLeft = 0`, `doneCount = 0` and `magnetronOn = 0`.
- Load latency: `timeLeft` shows `inDuration` one edge after a qualifying load cycle.
- First decrement occurs `TICKS_PER_SEC` running cycles after the load or resume point. The prescaler keeps its partial count across a pause.
- `doneCount` rises on the same edge that `timeLeft` goes 1→0. The FSM sees it in the following cycle.
- `magnetronOn` and `lampOn` lag `running` by one edge.
- Priority when events coincide: `reset` > `enReset` > load > tick.
  - `enReset` together with `enDuration` clears and does not load. The load happens on the next qualifying cycle.
  - A tick and `enOut` falling on the same edge: the tick is taken only if `running` was true in that cycle.
- Mid-countdown `reset` or `enReset` abandons the cook. `armed` = 0, so the next `enDuration` reloads even with `enOut` high.

## Test plan
All scenarios use `TICKS_PER_SEC = 4`.
- **Manual cook:** hold `enDuration` with `inDuration` 5 then 3, drop it, set `enHeatingLevel` with 11, then hold `enOut` → `timeLeft` follows 5 then 3; decrements every 4 cycles; `doneCount` rises on the 3→…→0 edge at cycle 12 of running; `magnetronOn` = 1 throughout.
- **Auto hold-load:** hold `enDuration`, `enOut` and `inDuration` = 10 together → load once, then 10→9 after 4 cycles (no re-load); `doneCount` at 40 cycles; `enReset` pulse → `doneCount` = 0, `timeLeft` = 0.
- **Duty:** level 00, duration 8 → `magnetronOn` high for 1 of every 4 seconds (phase 0 only); level 01 → 2 of 4.
- **Pause/resume:** drop `enOut` at `timeLeft` = 6 mid-prescale for 20 cycles, then raise `enOut` and `enDuration` → value holds at 6 with `lampOn` = 0; resumes with the remaining prescale, no reload.
- **Zero/edge:** load 0 then `enOut` → `doneCount` next edge, `timeLeft` stays 0 (no wrap to 65535); `enReset` with `enDuration` the same cycle → no load.
- **Async reset:** assert `reset` between clock edges mid-count → all outputs 0 immediately, with no clock edge needed.
